// File: rtl/phase_error_counter_pkg.sv
// Encodings and helpers shared between the phase-detector state machine and
// the phase-error accumulator.
package phase_error_counter_pkg;

  typedef enum logic [1:0] {
    CI_DISABLE    = 2'b00,
    CI_COUNT_UP   = 2'b01,
    CI_COUNT_DOWN = 2'b10
  } count_instr_e;

  // One-hot save-and-clear handshake states
  typedef enum logic [1:0] {
    HS_IDLE = 2'b01,
    HS_ACK  = 2'b10
  } hs_state_e;

  // Largest magnitude the symmetric clamp allows for a given width
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Signed up/down counter clamped to [-MAX, MAX]; clear has priority over counting.
module sat_updown_counter
  import phase_error_counter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  input  logic                    down_i,
  output logic signed [WIDTH-1:0] value_o,
  output logic                    at_limit_o
);

  localparam logic signed [WIDTH-1:0] MAX = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN = -MAX;

  logic signed [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d    = value_q;
    at_limit_o = (up_i && (value_q == MAX)) || (down_i && (value_q == MIN));
    if (clear_i) begin
      value_d = '0;
    end else if (up_i && (value_q != MAX)) begin
      value_d = value_q + WIDTH'(1);
    end else if (down_i && (value_q != MIN)) begin
      value_d = value_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/phase_error_counter.sv
// Phase-error accumulator with save-and-clear handshake: captures the count for
// the loop filter, clears, acknowledges, and flags measurements that clamped.
module phase_error_counter
  import phase_error_counter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic [1:0]              count_instr_i,
  input  logic                    save_and_clear_i,
  output logic                    counter_cleared_o,
  output logic signed [WIDTH-1:0] phase_error_o,
  output logic                    phase_error_valid_o,
  output logic                    saturated_o
);

  hs_state_e state_q, state_d;
  logic      capture;
  logic      up, down, at_limit;
  logic      sat_seen_q, sat_seen_d;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] phase_error_q, phase_error_d;
  logic      valid_q, valid_d;
  logic      saturated_q, saturated_d;

  assign up   = (count_instr_i == CI_COUNT_UP);
  assign down = (count_instr_i == CI_COUNT_DOWN);

  sat_updown_counter #(.WIDTH(WIDTH)) u_counter (
    .clk_i      (fpga_clk_i),
    .reset_i    (reset_i),
    .clear_i    (capture),
    .up_i       (up),
    .down_i     (down),
    .value_o    (acc),
    .at_limit_o (at_limit)
  );

  // Only the IDLE->ACK transition captures, so a held request yields one capture
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (save_and_clear_i) begin
          capture = 1'b1;
          state_d = HS_ACK;
        end
      end
      HS_ACK: begin
        if (!save_and_clear_i) state_d = HS_IDLE;
      end
      default: state_d = HS_IDLE;
    endcase
  end

  always_comb begin
    phase_error_d = phase_error_q;
    saturated_d   = saturated_q;
    valid_d       = capture;
    sat_seen_d    = sat_seen_q | at_limit;
    if (capture) begin
      phase_error_d = acc;
      saturated_d   = sat_seen_q;
      sat_seen_d    = 1'b0;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q       <= HS_IDLE;
      sat_seen_q    <= 1'b0;
      phase_error_q <= '0;
      valid_q       <= 1'b0;
      saturated_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sat_seen_q    <= sat_seen_d;
      phase_error_q <= phase_error_d;
      valid_q       <= valid_d;
      saturated_q   <= saturated_d;
    end
  end

  assign counter_cleared_o   = (state_q == HS_ACK);
  assign phase_error_o       = phase_error_q;
  assign phase_error_valid_o = valid_q;
  assign saturated_o         = saturated_q;

endmodule

// File: tb/tb_phase_error_counter.sv
// Drives a 16-bit and a 4-bit phase_error_counter with identical stimulus and
// checks both against a cycle-level behavioural model.
module tb_phase_error_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] instr;
  logic       save;

  logic              clr16, vld16, sat16;
  logic signed [15:0] pe16;
  logic              clr4, vld4, sat4;
  logic signed [3:0]  pe4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phase_error_counter #(.WIDTH(16)) dut16 (
    .fpga_clk_i          (clk),
    .reset_i             (rst),
    .count_instr_i       (instr),
    .save_and_clear_i    (save),
    .counter_cleared_o   (clr16),
    .phase_error_o       (pe16),
    .phase_error_valid_o (vld16),
    .saturated_o         (sat16)
  );

  phase_error_counter #(.WIDTH(4)) dut4 (
    .fpga_clk_i          (clk),
    .reset_i             (rst),
    .count_instr_i       (instr),
    .save_and_clear_i    (save),
    .counter_cleared_o   (clr4),
    .phase_error_o       (pe4),
    .phase_error_valid_o (vld4),
    .saturated_o         (sat4)
  );

  // Reference model: index 0 is WIDTH=16, index 1 is WIDTH=4
  int W[2] = '{16, 4};
  int m_acc[2], m_pe[2];
  bit m_sat[2], m_satout[2];
  bit m_vld, m_ack;

  logic [45:0] act;
  assign act = {clr16, vld16, sat16, pe16, clr4, vld4, sat4, pe4,
                dut16.acc, dut4.acc};

  function automatic logic [45:0] exp_vec();
    return {m_ack, m_vld, m_satout[0], 16'(m_pe[0]),
            m_ack, m_vld, m_satout[1], 4'(m_pe[1]),
            16'(m_acc[0]), 4'(m_acc[1])};
  endfunction

  task automatic step(input logic [1:0] i, input logic s, input logic r = 1'b0);
    bit cap;
    instr = i; save = s; rst = r;
    @(posedge clk);
    if (r) begin
      m_acc = '{0, 0}; m_pe = '{0, 0}; m_sat = '{0, 0}; m_satout = '{0, 0};
      m_vld = 0; m_ack = 0;
    end else begin
      cap = !m_ack && s;
      m_vld = cap;
      for (int k = 0; k < 2; k++) begin
        int mx;
        mx = (1 << (W[k] - 1)) - 1;
        if (cap) begin
          m_pe[k] = m_acc[k]; m_satout[k] = m_sat[k];
          m_acc[k] = 0; m_sat[k] = 0;
        end else if (i == 2'b01) begin
          if (m_acc[k] == mx) m_sat[k] = 1; else m_acc[k]++;
        end else if (i == 2'b10) begin
          if (m_acc[k] == -mx) m_sat[k] = 1; else m_acc[k]--;
        end
      end
      m_ack = s;
    end
    #1;
  endtask

  task automatic test_reset();
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);
    n_cmp++;
    if (act !== 46'd0) begin
      n_fail++; $display("FAIL reset_values: got %h want %h", act, 46'd0);
    end
    step(2'b00, 1'b0);
  endtask

  task automatic test_count_up();
    repeat (5) step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    step(2'b00, 1'b1);
    n_cmp++;
    if ({clr16, vld16, sat16, pe16} !== {3'b110, 16'sd5}) begin
      n_fail++; $display("FAIL up5_capture: got %b%b%b %0d want 110 5", clr16, vld16, sat16, pe16);
    end
    step(2'b00, 1'b1);
    n_cmp++;
    if ({clr16, vld16, pe16} !== {2'b10, 16'sd5}) begin
      n_fail++; $display("FAIL up5_hold: got %b%b %0d want 10 5", clr16, vld16, pe16);
    end
    step(2'b00, 1'b0);
    n_cmp++;
    if ({clr16, vld16} !== 2'b00 || act !== exp_vec()) begin
      n_fail++; $display("FAIL up5_release: got %h want %h", act, exp_vec());
    end
  endtask

  task automatic test_count_down();
    repeat (3) step(2'b10, 1'b0);
    step(2'b00, 1'b1);
    n_cmp++;
    if (pe16 !== 16'hFFFD || dut16.acc !== 16'sd0 || pe4 !== 4'hD) begin
      n_fail++; $display("FAIL down3: got pe16=%h acc=%0d pe4=%h want FFFD 0 D", pe16, dut16.acc, pe4);
    end
    step(2'b00, 1'b0);
  endtask

  task automatic test_saturation();
    repeat (10) step(2'b01, 1'b0);
    step(2'b00, 1'b1);
    n_cmp++;
    if (pe4 !== 4'sd7 || sat4 !== 1'b1 || pe16 !== 16'sd10 || sat16 !== 1'b0) begin
      n_fail++; $display("FAIL sat_up: got pe4=%0d sat4=%b pe16=%0d sat16=%b want 7 1 10 0", pe4, sat4, pe16, sat16);
    end
    step(2'b00, 1'b0);
    repeat (10) step(2'b10, 1'b0);
    step(2'b00, 1'b1);
    n_cmp++;
    if (pe4 !== 4'h9 || sat4 !== 1'b1) begin
      n_fail++; $display("FAIL sat_down: got pe4=%h sat4=%b want 9 1", pe4, sat4);
    end
    step(2'b00, 1'b0);
    repeat (2) step(2'b01, 1'b0);
    step(2'b00, 1'b1);
    n_cmp++;
    if (pe4 !== 4'sd2 || sat4 !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear: got pe4=%0d sat4=%b want 2 0", pe4, sat4);
    end
    step(2'b00, 1'b0);
  endtask

  task automatic test_long_save();
    int pulses = 0, hi = 0;
    logic signed [15:0] first_pe;
    step(2'b01, 1'b0);
    step(2'b00, 1'b1);
    first_pe = pe16;
    pulses += vld16; hi += clr16;
    repeat (5) begin
      step(2'b01, 1'b1);
      pulses += vld16; hi += clr16;
    end
    step(2'b00, 1'b0);
    pulses += vld16; hi += clr16;
    n_cmp++;
    if (pulses != 1 || hi != 6 || pe16 !== first_pe || first_pe !== 16'sd1) begin
      n_fail++; $display("FAIL long_save: got pulses=%0d hi=%0d pe=%0d want 1 6 1", pulses, hi, pe16);
    end
    step(2'b00, 1'b1);
    n_cmp++;
    if (pe16 !== 16'sd5 || vld16 !== 1'b1) begin
      n_fail++; $display("FAIL long_save_next: got %0d vld=%b want 5 1", pe16, vld16);
    end
    step(2'b00, 1'b0);
  endtask

  task automatic test_same_cycle();
    repeat (4) step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    n_cmp++;
    if (pe16 !== 16'sd4 || dut16.acc !== 16'sd0 || pe4 !== 4'sd4) begin
      n_fail++; $display("FAIL clear_priority: got pe=%0d acc=%0d want 4 0", pe16, dut16.acc);
    end
    step(2'b00, 1'b0);
  endtask

  task automatic test_reset_in_ack();
    step(2'b00, 1'b1);
    repeat (3) step(2'b01, 1'b1);
    n_cmp++;
    if (dut16.acc !== 16'sd3 || clr16 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got acc=%0d clr=%b want 3 1", dut16.acc, clr16);
    end
    step(2'b01, 1'b1, 1'b1);
    n_cmp++;
    if (act !== 46'd0) begin
      n_fail++; $display("FAIL reset_in_ack: got %h want 0", act);
    end
    repeat (4) step(2'b11, 1'b0);
    n_cmp++;
    if (act !== 46'd0) begin
      n_fail++; $display("FAIL instr11: got %h want 0", act);
    end
    repeat (2) step(2'b01, 1'b0);
    step(2'b01, 1'b1, 1'b1);
    n_cmp++;
    if (act !== 46'd0) begin
      n_fail++; $display("FAIL reset_on_capture: got %h want 0", act);
    end
    step(2'b00, 1'b0);
  endtask

  task automatic test_back_to_back();
    repeat (2) step(2'b10, 1'b0);
    step(2'b01, 1'b1);
    step(2'b01, 1'b0);
    n_cmp++;
    if (clr16 !== 1'b0 || vld16 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got clr=%b vld=%b want 0 0", clr16, vld16);
    end
    step(2'b00, 1'b1);
    n_cmp++;
    if (vld16 !== 1'b1 || pe16 !== 16'sd1 || act !== exp_vec()) begin
      n_fail++; $display("FAIL b2b_capture: got vld=%b pe=%0d want 1 1", vld16, pe16);
    end
    step(2'b00, 1'b0);
  endtask

  task automatic test_random();
    logic s = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [1:0] i;
      i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) s = ~s;
      step(i, s, ($urandom_range(0, 60) == 0));
      n_cmp++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL random_c%0d: got %h want %h", c, act, exp_vec());
      end
    end
    // Drive the 4-bit unit deep into both clamps with random holds
    for (int c = 0; c < 60; c++) begin
      step((c < 30) ? 2'b01 : 2'b10, ($urandom_range(0, 9) == 0));
      n_cmp++;
      if (act !== exp_vec()) begin
        n_fail++; $display("FAIL clamp_walk_c%0d: got %h want %h", c, act, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; instr = 2'b00; save = 1'b0;
    m_acc = '{0, 0}; m_pe = '{0, 0}; m_sat = '{0, 0}; m_satout = '{0, 0};
    m_vld = 0; m_ack = 0;
    #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_saturation();
    test_long_save();
    test_same_cycle();
    test_reset_in_ack();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_error_counter.md
# phase_error_counter

Signed up/down accumulator that sits directly downstream of the phase-detector state machine. It turns that machine's per-cycle count instruction into a two's-complement phase-error magnitude in fpga_clk_i cycles. On the save-and-clear handshake it latches the result for the loop filter, clears itself, and acknowledges. It also saturates, rather than wraps, on long phase gaps and flags the measurement when that happens.

## Interface
- WIDTH, 16: width of the accumulator and result, in bits; minimum 3.
- fpga_clk_i  input  1  system clock; all logic is on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- count_instr_i  input  2  00 DISABLE, 01 COUNT_UP, 10 COUNT_DOWN; 11 is treated as DISABLE.
- save_and_clear_i  input  1  level request from the state machine; high for the whole COPY_CLEAR state.
- counter_cleared_o  output  1  acknowledge; the state machine leaves COPY_CLEAR on it.
- phase_error_o  output  WIDTH  signed result of the last completed measurement; held until the next capture.
- phase_error_valid_o  output  1  one-cycle pulse when phase_error_o updates.
- saturated_o  output  1  the last captured measurement hit a clamp; updates together with phase_error_o.

## Operation
- The accumulator `acc` is signed WIDTH bits. Its clamp range is symmetric: MAX = 2^(WIDTH-1)-1, MIN = -MAX. The value -2^(WIDTH-1) is never produced.
- COUNT_UP: `acc` becomes min(acc+1, MAX). COUNT_DOWN: `acc` becomes max(acc-1, MIN).
- If a count instruction is issued while `acc` is already at the clamp in that direction, internal `sat_seen` is set. `sat_seen` is sticky until the next capture.
- Handshake FSM, 2 states, one-hot:
  - IDLE: counter_cleared_o=0.
    - If save_and_clear_i is high: capture, then go to ACK.
    - Otherwise stay in IDLE and count.
  - ACK: counter_cleared_o=1. Counting is enabled.
    - Stay in ACK while save_and_clear_i is high.
    - Go to IDLE on the first cycle save_and_clear_i is low.
- Capture happens in the cycle IDLE sees save_and_clear_i high. On that edge:
  - phase_error_o takes acc.
  - saturated_o takes sat_seen.
  - phase_error_valid_o becomes 1 for one cycle.
  - acc and sat_seen clear to 0.
  - Clear has priority: count_instr_i in the capture cycle is discarded.
- There is exactly one capture per save_and_clear_i assertion, however long the level is held.
- Counting in ACK starts from 0. This lets a new measurement begin while the acknowledge is still high.

## Timing
- Reset values: acc=0, sat_seen=0, state IDLE, counter_cleared_o=0, phase_error_o=0, phase_error_valid_o=0, saturated_o=0.
- Reset mid-operation, including in ACK or during a capture edge, forces all reset values on the next edge. No pulse is emitted.
- Count latency: the instruction in cycle N is reflected in acc in cycle N+1.
- Handshake with save_and_clear_i first high in cycle N:
  - N+1: phase_error_o and saturated_o are valid, phase_error_valid_o=1, counter_cleared_o=1, acc=0.
  - counter_cleared_o stays high until the cycle after save_and_clear_i is first seen low.
  - With the standard state machine: counter_cleared_o is high in N+1 and N+2, and the FSM returns to IDLE in N+3.
- save_and_clear_i rising again in the first IDLE cycle is a new capture.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Shared package, also used by the phase-detector state machine, holds:
  - count_instr encodings DISABLE/COUNT_UP/COUNT_DOWN;
  - the handshake state encodings IDLE/ACK;
  - a function returning MAX for a given WIDTH.
- One sub-module, `sat_updown_counter`:
  - parameter WIDTH; inputs clear, up, down;
  - outputs value and at_limit, where at_limit is a combinational clamp-hit for the current instruction.
  - The handshake FSM and output registers stay in the top.

## Test plan
- Reset, COUNT_UP for 5 cycles, DISABLE, then save held 2 cycles: phase_error_o=5 and a single valid pulse; counter_cleared_o high 2 cycles; saturated_o=0.
- COUNT_DOWN for 3 cycles, then save: phase_error_o=16'hFFFD (-3) and acc=0 afterwards.
- WIDTH=4: COUNT_UP for 10 cycles, then save: phase_error_o=7, saturated_o=1. Then COUNT_DOWN for 10 cycles and save: phase_error_o=-7 (4'h9), saturated_o=1. Then 2 up and save: 2, saturated_o=0.
- save_and_clear_i held 6 cycles with COUNT_UP throughout from the cycle after capture: one valid pulse, phase_error_o unchanged, counter_cleared_o high for 6 cycles; the next capture reads 5.
- COUNT_UP asserted in the same cycle save rises in IDLE after 4 prior ups: captured value is 4, not 5, and acc=0 the next cycle.
- reset_i pulsed while in ACK with acc=3: all outputs 0 next cycle, state IDLE, no valid pulse; count_instr 11 for 4 cycles leaves acc=0.
